mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 79 +++++++
 rtl/mem_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the CPU requesters, the arbiter and the memory macro.
// slave: arbiter view; master: requesters plus memory model.
interface mem_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic          i_err;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic          d_err;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          busy;

  modport slave (
    input  i_req,
    input  i_addr,
    output i_done,
    output i_err,
    output i_rdata,
    input  d_req,
    input  d_we,
    input  d_be,
    input  d_addr,
    input  d_wdata,
    output d_done,
    output d_err,
    output d_rdata,
    output mem_en,
    output mem_we,
    output mem_be,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready,
    output busy
  );

  modport master (
    output i_req,
    output i_addr,
    input  i_done,
    input  i_err,
    input  i_rdata,
    output d_req,
    output d_we,
    output d_be,
    output d_addr,
    output d_wdata,
    input  d_done,
    input  d_err,
    input  d_rdata,
    input  mem_en,
    input  mem_we,
    input  mem_be,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory between fetch and load/store.
// Fully registered outputs; hung accesses abort after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RSTn,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          i_done_q, i_done_d;
  logic          i_err_q, i_err_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic          d_done_q, d_done_d;
  logic          d_err_q, d_err_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;

  logic          req_any;
  logic          pick;
  logic          acc_ok;
  logic          acc_tmo;
  logic          acc_end;
  logic [DW-1:0] cap_rdata;

  // Pick the requester to grant; a tie goes to whoever was not served last.
  always_comb begin
    req_any = 1'b0;
    pick    = 1'b0;
    unique case (1'b1)
      bus.i_req & bus.d_req: begin
        req_any = 1'b1;
        pick    = ~last_q;
      end
      bus.i_req & ~bus.d_req: begin
        req_any = 1'b1;
        pick    = 1'b0;
      end
      ~bus.i_req & bus.d_req: begin
        req_any = 1'b1;
        pick    = 1'b1;
      end
      default: begin
        req_any = 1'b0;
        pick    = 1'b0;
      end
    endcase
  end

  // Access termination: memory answered, or the wait budget ran out.
  always_comb begin
    acc_ok    = (state_q == ACC) & bus.mem_ready;
    acc_tmo   = (state_q == ACC) & ~bus.mem_ready
              & (cnt_q == CNT_LAST);
    acc_end   = acc_ok | acc_tmo;
    cap_rdata = (acc_ok & ~mem_we_q) ? bus.mem_rdata : '0;
  end

  // State and arbitration registers.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: grant in IDLE, count waits in ACC, single RESP cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = ACC;
          owner_d = pick;
          last_d  = pick;
          cnt_d   = '0;
        end
      end
      ACC: begin
        if (acc_end) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs: latch the bus at grant, report at access end.
  always_comb begin
    i_done_d    = 1'b0;
    i_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = (state_d != IDLE);
    if ((state_q == IDLE) && req_any) begin
      mem_en_d = 1'b1;
      if (pick) begin
        mem_we_d    = bus.d_we;
        mem_be_d    = bus.d_be;
        mem_addr_d  = bus.d_addr;
        mem_wdata_d = bus.d_wdata;
      end else begin
        mem_we_d    = 1'b0;
        mem_be_d    = 4'b1111;
        mem_addr_d  = bus.i_addr;
        mem_wdata_d = '0;
      end
    end
    if (acc_end) begin
      mem_en_d = 1'b0;
      if (owner_q) begin
        d_done_d  = 1'b1;
        d_err_d   = acc_tmo;
        d_rdata_d = cap_rdata;
      end else begin
        i_done_d  = 1'b1;
        i_err_d   = acc_tmo;
        i_rdata_d = cap_rdata;
      end
    end
  end

  // Output register bank.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      i_done_q    <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      i_done_q    <= i_done_d;
      i_err_q     <= i_err_d;
      i_rdata_q   <= i_rdata_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.i_done    = i_done_q;
  assign bus.i_err     = i_err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Inputs change 1ns after each rising edge; outputs sampled there too.
module tb_mem_port_arbiter;

  logic CLK;
  logic RSTn;
  int   vec;
  int   miss;

  mem_port_arbiter_if #(.AW(12), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW(12),
    .DW(32),
    .TIMEOUT(15)
  ) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_be      = '0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    idle_inputs();
    tick();
    tick();
    vec++;
    if ({bus.mem_en, bus.busy, bus.i_done, bus.d_done,
         bus.i_err, bus.d_err, bus.mem_we} !== 7'b0) begin
      miss++;
      $display("FAIL reset_ctl: got %b want 0000000",
        {bus.mem_en, bus.busy, bus.i_done, bus.d_done,
         bus.i_err, bus.d_err, bus.mem_we});
    end
    vec++;
    if ({bus.mem_addr, bus.mem_be, bus.mem_wdata,
         bus.i_rdata, bus.d_rdata} !== '0) begin
      miss++;
      $display("FAIL reset_data: addr %h be %h wd %h ir %h dr %h want 0",
        bus.mem_addr, bus.mem_be, bus.mem_wdata,
        bus.i_rdata, bus.d_rdata);
    end
    RSTn = 1'b1;
  endtask

  task automatic test_zero_wait_fetch();
    bus.i_req     = 1'b1;
    bus.i_addr    = 12'h010;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0050_0093;
    tick();
    vec++;
    if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.busy}
        !== {1'b1, 1'b0, 4'hF, 12'h010, 1'b1}) begin
      miss++;
      $display("FAIL zw_grant: en %b we %b be %h addr %h busy %b want 1 0 f 010 1",
        bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.busy);
    end
    tick();
    vec++;
    if ({bus.i_done, bus.i_err, bus.d_done, bus.mem_en, bus.i_rdata}
        !== {4'b1000, 32'h0050_0093}) begin
      miss++;
      $display("FAIL zw_done: done %b err %b ddone %b en %b rd %h want 1 0 0 0 00500093",
        bus.i_done, bus.i_err, bus.d_done, bus.mem_en, bus.i_rdata);
    end
    bus.i_req     = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    vec++;
    if ({bus.i_done, bus.busy, bus.mem_en} !== 3'b000) begin
      miss++;
      $display("FAIL zw_idle: done %b busy %b en %b want 000",
        bus.i_done, bus.busy, bus.mem_en);
    end
  endtask

  task automatic test_store_waits();
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_be      = 4'b0011;
    bus.d_addr    = 12'h100;
    bus.d_wdata   = 32'hDEAD_BEEF;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.d_addr  = 12'h3FF;
    bus.d_wdata = 32'h0;
    bus.d_be    = 4'b1100;
    for (int j = 0; j < 4; j++) begin
      vec++;
      if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr,
           bus.mem_wdata, bus.d_done}
          !== {1'b1, 1'b1, 4'b0011, 12'h100, 32'hDEAD_BEEF, 1'b0}) begin
        miss++;
        $display("FAIL st_hold[%0d]: en %b we %b be %h addr %h wd %h done %b",
          j, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr,
          bus.mem_wdata, bus.d_done);
      end
      if (j == 3) bus.mem_ready = 1'b1;
      tick();
    end
    vec++;
    if ({bus.d_done, bus.d_err, bus.i_done, bus.mem_en, bus.d_rdata}
        !== {4'b1000, 32'h0}) begin
      miss++;
      $display("FAIL st_done: done %b err %b idone %b en %b rd %h want 1 0 0 0 0",
        bus.d_done, bus.d_err, bus.i_done, bus.mem_en, bus.d_rdata);
    end
    vec++;
    if (bus.i_rdata !== 32'h0050_0093) begin
      miss++;
      $display("FAIL st_irdata_hold: got %h want 00500093", bus.i_rdata);
    end
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    vec++;
    if ({bus.d_done, bus.busy} !== 2'b00) begin
      miss++;
      $display("FAIL st_idle: done %b busy %b want 00",
        bus.d_done, bus.busy);
    end
  endtask

  task automatic test_tie();
    logic [11:0] exp_addr;
    logic        is_d;
    test_reset();
    bus.i_req     = 1'b1;
    bus.i_addr    = 12'h020;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_be      = 4'b1111;
    bus.d_addr    = 12'h040;
    bus.mem_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      is_d     = (g % 2 == 0);
      exp_addr = is_d ? 12'h040 : 12'h020;
      bus.mem_rdata = 32'hA0 + 32'(g);
      tick();
      vec++;
      if ({bus.mem_en, bus.mem_addr} !== {1'b1, exp_addr}) begin
        miss++;
        $display("FAIL tie_grant[%0d]: en %b addr %h want 1 %h",
          g, bus.mem_en, bus.mem_addr, exp_addr);
      end
      tick();
      vec++;
      if ({bus.d_done, bus.i_done} !== {is_d, ~is_d}) begin
        miss++;
        $display("FAIL tie_done[%0d]: d %b i %b want %b %b",
          g, bus.d_done, bus.i_done, is_d, ~is_d);
      end
      vec++;
      if ((is_d ? bus.d_rdata : bus.i_rdata) !== 32'hA0 + 32'(g)) begin
        miss++;
        $display("FAIL tie_rdata[%0d]: d %h i %h want %h",
          g, bus.d_rdata, bus.i_rdata, 32'hA0 + 32'(g));
      end
      tick();
      vec++;
      if (bus.busy !== 1'b0) begin
        miss++;
        $display("FAIL tie_idle[%0d]: busy %b want 0", g, bus.busy);
      end
    end
    bus.i_req     = 1'b0;
    bus.d_req     = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_be      = 4'b1111;
    bus.d_addr    = 12'h055;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    n = 0;
    while (bus.mem_en === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    vec++;
    if (n != 15) begin
      miss++;
      $display("FAIL tmo_len: en cycles %0d want 15", n);
    end
    vec++;
    if ({bus.d_done, bus.d_err, bus.i_done, bus.d_rdata}
        !== {3'b110, 32'h0}) begin
      miss++;
      $display("FAIL tmo_done: done %b err %b idone %b rd %h want 1 1 0 0",
        bus.d_done, bus.d_err, bus.i_done, bus.d_rdata);
    end
    bus.d_req = 1'b0;
    tick();
    bus.d_req     = 1'b1;
    bus.d_addr    = 12'h066;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    vec++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 12'h066}) begin
      miss++;
      $display("FAIL tmo_next_grant: en %b addr %h want 1 066",
        bus.mem_en, bus.mem_addr);
    end
    tick();
    vec++;
    if ({bus.d_done, bus.d_err, bus.d_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
      miss++;
      $display("FAIL tmo_next_done: done %b err %b rd %h want 1 0 0badf00d",
        bus.d_done, bus.d_err, bus.d_rdata);
    end
    bus.d_req     = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    bus.i_req     = 1'b1;
    bus.i_addr    = 12'h030;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    RSTn = 1'b0;
    tick();
    vec++;
    if ({bus.mem_en, bus.busy, bus.i_done, bus.d_done, bus.mem_addr}
        !== {4'b0000, 12'h000}) begin
      miss++;
      $display("FAIL mr_reset: en %b busy %b id %b dd %b addr %h want 0",
        bus.mem_en, bus.busy, bus.i_done, bus.d_done, bus.mem_addr);
    end
    RSTn      = 1'b1;
    bus.i_req = 1'b0;
    tick();
    vec++;
    if ({bus.i_done, bus.busy} !== 2'b00) begin
      miss++;
      $display("FAIL mr_no_done: done %b busy %b want 00",
        bus.i_done, bus.busy);
    end
    bus.i_req     = 1'b1;
    bus.i_addr    = 12'h031;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    tick();
    vec++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 12'h031}) begin
      miss++;
      $display("FAIL mr_regrant: en %b addr %h want 1 031",
        bus.mem_en, bus.mem_addr);
    end
    tick();
    vec++;
    if ({bus.i_done, bus.i_rdata} !== {1'b1, 32'h1111_2222}) begin
      miss++;
      $display("FAIL mr_done: done %b rd %h want 1 11112222",
        bus.i_done, bus.i_rdata);
    end
    bus.i_req     = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    int dones;
    bus.i_req     = 1'b1;
    bus.i_addr    = 12'h044;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h7777_8888;
    tick();
    bus.i_req = 1'b0;
    dones = 0;
    tick();
    dones += int'(bus.i_done);
    tick();
    dones += int'(bus.i_done);
    bus.mem_ready = 1'b1;
    tick();
    dones += int'(bus.i_done);
    vec++;
    if ({bus.i_done, bus.i_rdata} !== {1'b1, 32'h7777_8888}) begin
      miss++;
      $display("FAIL wd_done: done %b rd %h want 1 77778888",
        bus.i_done, bus.i_rdata);
    end
    bus.mem_ready = 1'b0;
    tick();
    dones += int'(bus.i_done);
    tick();
    dones += int'(bus.i_done);
    vec++;
    if (dones != 1) begin
      miss++;
      $display("FAIL wd_pulses: got %0d want 1", dones);
    end
    vec++;
    if ({bus.mem_en, bus.busy} !== 2'b00) begin
      miss++;
      $display("FAIL wd_no_regrant: en %b busy %b want 00",
        bus.mem_en, bus.busy);
    end
  endtask

  initial begin
    vec  = 0;
    miss = 0;
    test_reset();
    test_zero_wait_fetch();
    test_store_waits();
    test_tie();
    test_timeout();
    test_mid_reset();
    test_withdraw();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
